// File: rtl/dr_sync_capture.sv
// Clocked receiver for a dual-rail completion detector: synchronises done, captures
// the settled word into a valid/ready register and drives the return-to-zero acknowledge.
module dr_sync_capture #(
  parameter int W           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic         cp,
  input  logic         cdn,
  input  logic [W-1:0] d_1,
  input  logic [W-1:0] d_0,
  input  logic         done,
  output logic         ack,
  output logic [W-1:0] q,
  output logic         q_valid,
  input  logic         q_ready,
  output logic         err,
  output logic         tout
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {RST_SP, EVAL, RTZ} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ack_q, ack_d;
  logic [W-1:0]           q_q, q_d;
  logic                   qv_q, qv_d;
  logic                   err_q, err_d;
  logic                   tout_q, tout_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   done_s;
  logic                   slot_free;
  logic                   capture;
  logic                   count;

  assign sync_d    = {sync_q[SYNC_STAGES-2:0], done};
  assign done_s    = sync_q[SYNC_STAGES-1];
  assign slot_free = ~qv_q | q_ready;

  always_ff @(posedge cp) begin
    if (!cdn) begin
      state_q <= RST_SP;
      sync_q  <= '1;
      ack_q   <= 1'b1;
      q_q     <= '0;
      qv_q    <= 1'b0;
      err_q   <= 1'b0;
      tout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      err_q   <= err_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    q_d     = q_q;
    qv_d    = qv_q & ~q_ready;
    err_d   = err_q;
    tout_d  = tout_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    count   = 1'b0;

    case (state_q)
      RST_SP, RTZ: begin
        count = 1'b1;
        if (!done_s) begin
          state_d = EVAL;
          ack_d   = 1'b0;
        end
      end
      EVAL: begin
        if (!done_s) begin
          count = 1'b1;
        end else if (slot_free) begin
          capture = 1'b1;
          state_d = RTZ;
          ack_d   = 1'b1;
        end
      end
      default: begin
        state_d = RST_SP;
        ack_d   = 1'b1;
      end
    endcase

    // A pair with both rails equal is a code violation; the word is still taken.
    if (capture) begin
      q_d  = d_1;
      qv_d = 1'b1;
      if (|(~(d_1 ^ d_0))) err_d = 1'b1;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (count && (TIMEOUT != 0)) begin
      cnt_d = (cnt_q == TMAX) ? cnt_q : cnt_q + CNT_W'(1);
      if (cnt_d == TMAX) tout_d = 1'b1;
    end
  end

  assign ack     = ack_q;
  assign q       = q_q;
  assign q_valid = qv_q;
  assign err     = err_q;
  assign tout    = tout_q;

endmodule

// File: tb/tb_dr_sync_capture.sv
// Bench for dr_sync_capture: directed vector table, handshake corner sequences and a
// randomised datapath emulation checked against a phase-level reference model.
module tb_dr_sync_capture;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int TO = 10;

  logic         cp = 1'b0;
  logic         cdn, done, q_ready;
  logic [W-1:0] d_1, d_0;
  logic         ack, q_valid, err, tout;
  logic [W-1:0] q;

  int checks   = 0;
  int failures = 0;

  dr_sync_capture #(.W(W), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .cp(cp), .cdn(cdn), .d_1(d_1), .d_0(d_0), .done(done), .ack(ack),
    .q(q), .q_valid(q_valid), .q_ready(q_ready), .err(err), .tout(tout)
  );

  always #5 cp = ~cp;

  // Reference model: ack=1 means waiting for spacer, ack=0 waiting for data;
  // done_s is the done value sampled SS edges earlier (1 before enough history).
  bit           m_ack, m_qv, m_err, m_tout;
  logic [W-1:0] m_q;
  int           m_cnt;
  bit           dq[$];

  task automatic model_edge();
    bit ds, toggle, cap, counting;
    if (!cdn) begin
      m_ack = 1; m_q = '0; m_qv = 0; m_err = 0; m_tout = 0; m_cnt = 0;
      dq.delete();
    end else begin
      ds = (dq.size() >= SS) ? dq[dq.size() - SS] : 1'b1;
      toggle = 0; cap = 0;
      if (m_ack) toggle = !ds;
      else if (ds && (!m_qv || q_ready)) begin toggle = 1; cap = 1; end
      counting = m_ack || !ds;
      if (cap) begin
        m_q = d_1;
        for (int i = 0; i < W; i++) if (d_1[i] == d_0[i]) m_err = 1;
      end
      m_qv = cap ? 1'b1 : (q_ready ? 1'b0 : m_qv);
      if (toggle) m_cnt = 0;
      else if (counting) begin
        if (m_cnt < TO) m_cnt++;
        if (m_cnt >= TO) m_tout = 1;
      end
      if (toggle) m_ack = !m_ack;
      dq.push_back(done);
      if (dq.size() > 8) void'(dq.pop_front());
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge cp);
    model_edge();
    #1;
    chk("model_ack", ack, m_ack);
    chk("model_q", q, m_q);
    chk("model_q_valid", q_valid, m_qv);
    chk("model_err", err, m_err);
    chk("model_tout", tout, m_tout);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_out(input string nm, input bit e_ack, input logic [W-1:0] e_q,
                         input bit e_qv, input bit e_err, input bit e_tout);
    chk({nm, "_ack"}, ack, e_ack);
    chk({nm, "_q"}, q, e_q);
    chk({nm, "_qv"}, q_valid, e_qv);
    chk({nm, "_err"}, err, e_err);
    chk({nm, "_tout"}, tout, e_tout);
  endtask

  typedef struct {
    bit           cdn, done, rdy;
    logic [W-1:0] d1, d0;
    bit           e_ack;
    logic [W-1:0] e_q;
    bit           e_qv, e_err, e_tout;
  } vec_t;

  vec_t tbl[11];

  initial begin
    cdn = 0; done = 0; q_ready = 0; d_1 = '0; d_0 = '0;

    //            cdn done rdy d1     d0     ack q     qv err tout
    tbl[0]  = '{0, 0, 0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0};
    tbl[5]  = '{1, 1, 1, 4'hA, 4'h5, 0, 4'h0, 0, 0, 0};
    tbl[6]  = '{1, 1, 1, 4'hA, 4'h5, 0, 4'h0, 0, 0, 0};
    tbl[7]  = '{1, 1, 1, 4'hA, 4'h5, 1, 4'hA, 1, 0, 0};
    tbl[8]  = '{1, 0, 1, 4'h0, 4'h0, 1, 4'hA, 0, 0, 0};
    tbl[9]  = '{1, 0, 1, 4'h0, 4'h0, 1, 4'hA, 0, 0, 0};
    tbl[10] = '{1, 0, 1, 4'h0, 4'h0, 0, 4'hA, 0, 0, 0};

    for (int i = 0; i < 11; i++) begin
      cdn = tbl[i].cdn; done = tbl[i].done; q_ready = tbl[i].rdy;
      d_1 = tbl[i].d1; d_0 = tbl[i].d0;
      tick();
      chk_out($sformatf("tbl%0d", i), tbl[i].e_ack, tbl[i].e_q, tbl[i].e_qv,
              tbl[i].e_err, tbl[i].e_tout);
    end

    // Timeout: done held low in EVAL for TO counting cycles.
    q_ready = 0;
    ticks(TO - 1);
    chk("tout_before", tout, 0);
    tick();
    chk("tout_at_limit", tout, 1);
    done = 1; d_1 = 4'h3; d_0 = 4'hC;
    ticks(3);
    chk_out("tok_after_tout", 1, 4'h3, 1, 0, 1);
    done = 0; d_1 = '0; d_0 = '0;
    ticks(3);
    chk("ack_fall_after_tout", ack, 0);

    // Backpressure: first word unconsumed, second token completes.
    done = 1; d_1 = 4'hC; d_0 = 4'h3;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out($sformatf("bp_hold%0d", i), 0, 4'h3, 1, 0, 1);
    end
    q_ready = 1;
    tick();
    chk_out("bp_release", 1, 4'hC, 1, 0, 1);
    done = 0; d_1 = '0; d_0 = '0;
    ticks(3);
    chk("bp_ack_fall", ack, 0);

    // Code violation on bit 2 only, then a clean token.
    done = 1; d_1 = 4'b0110; d_0 = 4'b1101;
    ticks(3);
    chk_out("viol", 1, 4'h6, 1, 1, 1);
    done = 0; d_1 = '0; d_0 = '0;
    ticks(3);
    done = 1; d_1 = 4'h9; d_0 = 4'h6;
    ticks(3);
    chk_out("viol_sticky", 1, 4'h9, 1, 1, 1);

    // Reset in RTZ with done still high: ack must stay high until done falls.
    cdn = 0;
    tick();
    chk_out("rst_rtz", 1, 4'h0, 0, 0, 0);
    cdn = 1;
    ticks(5);
    chk_out("rst_wait", 1, 4'h0, 0, 0, 0);
    done = 0; d_1 = '0; d_0 = '0;
    ticks(2);
    chk("rst_ack_hold", ack, 1);
    tick();
    chk("rst_ack_fall", ack, 0);

    // Randomised datapath: done follows !ack after a random delay, occasional long stalls.
    for (int n = 0; n < 4000; n++) begin
      cdn = ($urandom_range(0, 299) != 0);
      q_ready = $urandom_range(0, 1);
      if (done == m_ack && $urandom_range(0, 2) == 0 && $urandom_range(0, 19) != 0) begin
        done = !m_ack;
        if (done) begin
          d_1 = W'($urandom);
          d_0 = ($urandom_range(0, 7) == 0) ? W'($urandom) : ~d_1;
        end else begin
          d_1 = '0; d_0 = '0;
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dr_sync_capture.md
# dr_sync_capture

Synchronous receiver that sits directly downstream of a dual-rail completion detector in the asynchronous comparator datapath. It synchronises the detector's completion output, captures the settled dual-rail word as a single-rail value, and closes the four-phase return-to-zero handshake by driving the acknowledge back into the datapath. Captured words are presented to the clocked system through a valid/ready register. Rail-code errors and handshake stalls are flagged.

## Interface
- W, 4, data width in bits (dual-rail pairs)
- SYNC_STAGES, 2, flops in the `done` synchroniser (min 2)
- TIMEOUT, 255, cycles allowed in any wait state before `tout` sets; 0 disables; counter width clog2(TIMEOUT+1)

- cp  in  1  clock, rising edge
- cdn  in  1  synchronous active-low reset
- d_1  in  W  true rails from datapath (asynchronous)
- d_0  in  W  false rails from datapath (asynchronous)
- done  in  1  completion detector output (asynchronous): 1 = all pairs valid, 0 = all spacer
- ack  out  1  acknowledge to datapath; 1 forces datapath to spacer
- q  out  W  captured single-rail word
- q_valid  out  1  q holds an unconsumed word
- q_ready  in  1  consumer accepts q this cycle
- err  out  1  sticky rail-code violation
- tout  out  1  sticky handshake timeout

## Operation
- `done` passes through SYNC_STAGES flops → `done_s`. Sync flops reset to 1.
- FSM states: RST_SP, EVAL, RTZ.
  - RST_SP (reset state, ack=1): on done_s=0 → ack<=0, go EVAL.
  - EVAL (ack=0): on done_s=1 and slot free (q_valid=0 or q_ready=1) → q<=d_1, q_valid<=1, ack<=1, go RTZ. If done_s=1 but slot not free → hold in EVAL, ack stays 0 (backpressure holds datapath in valid phase).
  - RTZ (ack=1): on done_s=0 → ack<=0, go EVAL.
- Capture check: any bit with d_1[i]==d_0[i] at the capture edge sets err<=1. The word is still captured and the handshake proceeds normally. err clears only on reset.
- q_valid clears on q_ready=1 when no capture occurs that cycle. Capture and consume on the same edge: q_valid stays 1 and q takes the new word.
- q holds its value after consumption; it changes only on capture or reset.
- Timeout counter:
  - Clears on every state change.
  - Increments each cycle spent in RST_SP, in RTZ, or in EVAL with done_s=0. It does not increment while EVAL is blocked by backpressure.
  - Reaching TIMEOUT sets tout<=1 (sticky). Counter saturates. FSM is unaffected.
- d_1/d_0 are not synchronised. They are guaranteed stable because the datapath holds them until ack rises, and done_s lags done by ≥SYNC_STAGES cycles.

## Timing
- Reset values (cdn=0 at an edge): ack=1, q=0, q_valid=0, err=0, tout=0, state=RST_SP, sync flops=1, counter=0. Reset asserted mid-handshake behaves identically; ack=1 returns the datapath to spacer.
- Leaving reset with done=0: ack falls SYNC_STAGES+1 edges after cdn deasserts.
- done rise → q_valid=1 and ack=1 on edge SYNC_STAGES+1, provided the slot is free.
- done fall → ack=0 on edge SYNC_STAGES+1.
- Minimum token period: 2·(SYNC_STAGES+1) cycles plus datapath delays.
- ack is a registered output. q, q_valid, err and tout change only on cp rising edges.

## Test plan
- Reset with done=0, W=4: ack=1, q=0, q_valid=0 during reset. ack=0 at edge 3 after release. err=0, tout=0.
- Token d_1=4'b1010, d_0=4'b0101, done rises, q_ready=1:
  - q=4'hA and q_valid=1 three edges after done rise; ack=1 same edge; err=0.
  - done falls → ack=0 three edges later.
- Backpressure: q_valid=1 held, q_ready=0, second token completes. FSM stays in EVAL with ack=0 and q unchanged. When q_ready=1, the next edge loads the second word, q_valid stays 1 and ack rises.
- Code violation: bit 2 with d_1=d_0=1 at capture → err=1 and persists through later clean tokens until cdn=0.
- Timeout, TIMEOUT=10: done held 0 in EVAL → tout=1 at the 10th counting cycle. A later token still completes normally.
- Reset mid-RTZ (ack=1, done=1): cdn=0 for one edge → q_valid=0, q=0, ack=1, err=0, tout=0. FSM waits for done=0 before lowering ack.
